// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI monarch: FSM state encoding, word
// length, and the divider preset that keeps SCLK high through the front porch.
package spi_pkg;

  localparam int SPI_LEN = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRONT = 2'd1,
    SHIFT = 2'd2,
    BACK  = 2'd3
  } spi_state_t;

  // Divider preset: MSB set (SCLK high) with only four counts left before wrap.
  function automatic int spi_pre(input int div_w);
    return (1 << (div_w - 1)) + 3;
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK divider: owns the divider counter, derives SCLK from its MSB and decodes
// the sample (SCLK about to rise) and shift (SCLK about to fall) events.
module spi_sclk_div
  import spi_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_load,
  output logic o_sclk,
  output logic o_smpl,
  output logic o_shft
);

  localparam logic [DIV_W-1:0] L_PRE  = DIV_W'(spi_pre(DIV_W));
  localparam logic [DIV_W-1:0] L_SMPL = DIV_W'((1 << (DIV_W - 1)) - 1);

  logic [DIV_W-1:0] r_div;

  // Loading the preset on the final shift keeps SCLK from falling at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= L_PRE;
    end else if (i_load || !i_run) begin
      r_div <= L_PRE;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign o_sclk = r_div[DIV_W-1];
  assign o_smpl = (r_div == L_SMPL);
  assign o_shft = (r_div == '1);

endmodule

// File: rtl/spi_mnrch.sv
// SPI monarch: one 16-bit mode-3 full-duplex transfer per accepted wrt strobe.
// Optional macro SPI_MISO_SYNC_EN adds a two-flop MISO synchronizer before sampling.
module spi_mnrch
  import spi_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrt,
  input  logic [SPI_LEN-1:0] cmd,
  output logic               done,
  output logic [SPI_LEN-1:0] rd_data,
  output logic               SS_n,
  output logic               SCLK,
  output logic               MOSI,
  input  logic               MISO,
  output spi_state_t         o_dbg_state
);

  // Handshake: wrt is a one-cycle request honoured only in IDLE (even while done=1);
  // done then stays high, with rd_data valid, until the next honoured wrt.

  spi_state_t         r_state, w_nxt_state;
  logic [SPI_LEN-1:0] r_shft;
  logic [4:0]         r_bits;
  logic               r_done, r_ss_n, r_miso_smpl;
  logic               w_miso, w_smpl_evt, w_shft_evt, w_accept, w_finish, w_shift_en;

`ifdef SPI_MISO_SYNC_EN
  logic r_miso_s1, r_miso_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_miso_s1 <= MISO;
      r_miso_s2 <= r_miso_s1;
    end
  end

  assign w_miso = r_miso_s2;
`else
  assign w_miso = MISO;
`endif

  assign w_accept   = (r_state == IDLE) && wrt;
  assign w_finish   = (r_state == BACK) && w_shft_evt;
  // The shift event seen in FRONT is skipped: bit 15 is already on MOSI.
  assign w_shift_en = w_shft_evt && ((r_state == SHIFT) || (r_state == BACK));

  spi_sclk_div #(.DIV_W(DIV_W)) u_div (
    .clk    (clk),
    .rst    (rst),
    .i_run  (w_accept || (r_state != IDLE)),
    .i_load (w_finish),
    .o_sclk (SCLK),
    .o_smpl (w_smpl_evt),
    .o_shft (w_shft_evt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      IDLE:  if (wrt) w_nxt_state = FRONT;
      FRONT: if (w_shft_evt) w_nxt_state = SHIFT;
      SHIFT: if (w_smpl_evt && (r_bits == 5'(SPI_LEN - 1))) w_nxt_state = BACK;
      BACK:  if (w_shft_evt) w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shft      <= '0;
      r_bits      <= '0;
      r_done      <= 1'b0;
      r_ss_n      <= 1'b1;
      r_miso_smpl <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shft <= cmd;
        r_bits <= '0;
        r_done <= 1'b0;
        r_ss_n <= 1'b0;
      end else if (w_shift_en) begin
        r_shft <= {r_shft[SPI_LEN-2:0], r_miso_smpl};
        r_bits <= r_bits + 5'd1;
      end
      if (w_finish) begin
        r_ss_n <= 1'b1;
        r_done <= 1'b1;
      end
      if (w_smpl_evt && (r_state != IDLE)) begin
        r_miso_smpl <= w_miso;
      end
    end
  end

  assign done        = r_done;
  assign SS_n        = r_ss_n;
  assign rd_data     = r_shft;
  assign MOSI        = r_shft[SPI_LEN-1];
  assign o_dbg_state = r_state;

endmodule
